// File: rtl/gpi_bus_if.sv
// -----------------------------------------------------------------------------
// gpi_bus_if
// Single-cycle register bus between a host (master) and the GPI edge port
// (slave).
//
// Handshake: a transfer happens in every cycle where iSTB is high. The slave
// returns oACK combinationally in that same cycle, so there are no wait
// states. With iWE=1 the write commits on the rising clock edge that ends
// the cycle. With iWE=0, oDAT carries the addressed register during the
// cycle and is 32'h0 at all other times.
//
// Signals
//   iADR  32  byte address (only [3:2] decoded by the slave)
//   iDAT  32  write data
//   iWE    1  1 = write, 0 = read
//   iSTB   1  transfer strobe, active-high
//   oDAT  32  read data
//   oACK   1  acknowledge
// -----------------------------------------------------------------------------
interface gpi_bus_if;
  logic [31:0] iADR;
  logic [31:0] iDAT;
  logic        iWE;
  logic        iSTB;
  logic [31:0] oDAT;
  logic        oACK;

  modport master (
    output iADR,
    output iDAT,
    output iWE,
    output iSTB,
    input  oDAT,
    input  oACK
  );

  modport slave (
    input  iADR,
    input  iDAT,
    input  iWE,
    input  iSTB,
    output oDAT,
    output oACK
  );
endinterface

// File: rtl/gpi_edge_port.sv
// -----------------------------------------------------------------------------
// gpi_edge_port
// A general-purpose input port with W channels. Each channel goes through:
//   1. a SYNC_STAGES-deep synchronizer, which protects against metastability;
//   2. a per-channel debounce filter, which accepts a new level only after
//      the synchronized input has differed from the current level for
//      DB_CNT+1 consecutive cycles;
//   3. rise/fall edge detection, gated by enable registers, which sets
//      sticky write-1-to-clear STATUS bits.
// oIRQ is the registered OR of STATUS.
//
// Register map (only address bits [3:2] are decoded):
//   0x0 DATA     RO    debounced levels
//   0x4 RISE_EN  RW    per-channel rising-edge enable
//   0x8 FALL_EN  RW    per-channel falling-edge enable
//   0xC STATUS   RW1C  edge flags. When a set and a clear hit the same bit
//                      in the same cycle, the set wins.
// Register bits [31:W] read as 0 and ignore writes.
//
// Ports
//   iCLK   in   1   clock; all state changes on the rising edge
//   iRST   in   1   asynchronous reset, active-high
//   iDIn   in   W   external asynchronous inputs
//   bus    slave    register bus (see gpi_bus_if)
//   oIRQ   out  1   level interrupt, registered
// -----------------------------------------------------------------------------
module gpi_edge_port #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 3,
  parameter int DB_CNT      = 4
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [W-1:0]  iDIn,
  gpi_bus_if.slave      bus,
  output logic          oIRQ
);

  // The counter is wide enough to hold DB_CNT and is never narrower than
  // one bit, so DB_CNT=0 still builds.
  localparam int            CW     = (DB_CNT < 1) ? 1 : $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CNT);

  localparam logic [1:0] SEL_DATA    = 2'd0;
  localparam logic [1:0] SEL_RISE_EN = 2'd1;
  localparam logic [1:0] SEL_FALL_EN = 2'd2;
  localparam logic [1:0] SEL_STATUS  = 2'd3;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic [W-1:0] syncQ [SYNC_STAGES];
  logic [W-1:0] sync;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        syncQ[s] <= '0;
      end
    end else begin
      syncQ[0] <= iDIn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        syncQ[s] <= syncQ[s-1];
      end
    end
  end

  assign sync = syncQ[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce
  // cnt[i] counts consecutive cycles in which sync[i] differs from stable[i].
  // While cnt[i] counts up from 0, the new level is accepted on the
  // (DB_CNT+1)-th consecutive mismatching edge, and cnt[i] clears on that
  // same edge. Any agreement between sync[i] and stable[i] restarts the
  // count, so a pulse shorter than DB_CNT+1 cycles never changes stable[i].
  // ---------------------------------------------------------------------------
  logic [W-1:0]  stable;
  logic [W-1:0]  stableNxt;
  logic [CW-1:0] cnt    [W];
  logic [CW-1:0] cntNxt [W];

  always_comb begin
    stableNxt = stable;
    for (int i = 0; i < W; i++) begin
      cntNxt[i] = '0;
      if (sync[i] != stable[i]) begin
        if (cnt[i] == DB_MAX) begin
          stableNxt[i] = sync[i];
          cntNxt[i]    = '0;
        end else begin
          cntNxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stable <= '0;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stableNxt;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= cntNxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [1:0]   regSel;
  logic         wrStb;
  logic         rdStb;
  logic [W-1:0] wrData;

  assign regSel = bus.iADR[3:2];
  assign wrStb  = bus.iSTB & bus.iWE;
  assign rdStb  = bus.iSTB & ~bus.iWE;
  assign wrData = bus.iDAT[W-1:0];

  // The upper address bits and the write-data bits above W are not decoded.
  // They are folded into this signal only so that they count as consumed.
  logic unusedBusBits;
  assign unusedBusBits = ^{bus.iADR, bus.iDAT};

  // ---------------------------------------------------------------------------
  // Enable registers
  // A write updates the enable on its commit edge. Edge detection on that
  // same edge still uses the previous enable value.
  // ---------------------------------------------------------------------------
  logic [W-1:0] riseEn;
  logic [W-1:0] fallEn;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      riseEn <= '0;
      fallEn <= '0;
    end else if (wrStb) begin
      if (regSel == SEL_RISE_EN) begin
        riseEn <= wrData;
      end
      if (regSel == SEL_FALL_EN) begin
        fallEn <= wrData;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection and STATUS
  // An edge is detected from stable and stableNxt, so the STATUS bit sets on
  // the same edge on which the debounced level changes. The set term is
  // OR-ed in after the clear mask, which gives the set priority when both
  // hit the same bit. Clearing an enable leaves STATUS untouched.
  // ---------------------------------------------------------------------------
  logic [W-1:0] status;
  logic [W-1:0] statusNxt;
  logic [W-1:0] riseEv;
  logic [W-1:0] fallEv;
  logic [W-1:0] clrMask;

  assign riseEv  = ~stable &  stableNxt & riseEn;
  assign fallEv  =  stable & ~stableNxt & fallEn;
  assign clrMask = (wrStb && (regSel == SEL_STATUS)) ? wrData : '0;

  always_comb begin
    statusNxt = (status & ~clrMask) | riseEv | fallEv;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      status <= '0;
    end else begin
      status <= statusNxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt
  // oIRQ is registered from the STATUS register, not from statusNxt. It
  // therefore follows STATUS by exactly one edge, both when a bit sets and
  // when the last bit clears.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oIRQ <= 1'b0;
    end else begin
      oIRQ <= |status;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and acknowledge
  // The read path is combinational from the registers, so data is valid in
  // the same cycle as the strobe.
  // ---------------------------------------------------------------------------
  logic [31:0] rdData;

  always_comb begin
    rdData = 32'h0;
    if (rdStb) begin
      case (regSel)
        SEL_DATA:    rdData = 32'(stable);
        SEL_RISE_EN: rdData = 32'(riseEn);
        SEL_FALL_EN: rdData = 32'(fallEn);
        SEL_STATUS:  rdData = 32'(status);
        default:     rdData = 32'h0;
      endcase
    end
  end

  assign bus.oDAT = rdData;
  assign bus.oACK = bus.iSTB;

endmodule

// File: tb/tb_gpi_edge_port.sv
// -----------------------------------------------------------------------------
// tb_gpi_edge_port
// Directed bench for gpi_edge_port with W=8, SYNC_STAGES=3, DB_CNT=4.
// Each expected value is worked out by hand from the timing rule: a level
// applied before edge 1 appears in DATA on edge 3+4+1 = 8. STATUS sets on
// that same edge, and oIRQ follows one edge later.
// Inputs change 1 time unit after a rising edge. Outputs are sampled in the
// same low-activity window, never on an edge.
// -----------------------------------------------------------------------------
module tb_gpi_edge_port;

  localparam int W = 8;

  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_RISE   = 32'h4;
  localparam logic [31:0] A_FALL   = 32'h8;
  localparam logic [31:0] A_STATUS = 32'hC;

  // ---------------------------------------------------------------------------
  // Clock, reset, DUT
  // ---------------------------------------------------------------------------
  logic         iCLK = 1'b0;
  logic         iRST;
  logic [W-1:0] iDIn;
  logic         oIRQ;

  gpi_bus_if bus ();

  always #5 iCLK = ~iCLK;

  gpi_edge_port #(
    .W           (W),
    .SYNC_STAGES (3),
    .DB_CNT      (4)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .iDIn (iDIn),
    .bus  (bus),
    .oIRQ (oIRQ)
  );

  // ---------------------------------------------------------------------------
  // Checker and counters
  // ---------------------------------------------------------------------------
  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat);
    bus.iADR = adr;
    bus.iDAT = dat;
    bus.iWE  = 1'b1;
    bus.iSTB = 1'b1;
    tick();
    bus.iSTB = 1'b0;
    bus.iWE  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] adr, output logic [31:0] dat);
    bus.iADR = adr;
    bus.iWE  = 1'b0;
    bus.iSTB = 1'b1;
    #1;
    dat = bus.oDAT;
    bus.iSTB = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] adr,
                           input logic [31:0] exp);
    logic [31:0] d;
    bus_read(adr, d);
    check(tag, d, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    iRST     = 1'b1;
    iDIn     = '0;
    bus.iADR = '0;
    bus.iDAT = '0;
    bus.iWE  = 1'b0;
    bus.iSTB = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_irq", {31'b0, oIRQ}, 32'h0);
    check_reg("rst_data", A_DATA, 32'h0);
    check_reg("rst_status", A_STATUS, 32'h0);
    iRST = 1'b0;
    repeat (2) tick();

    // DATA latency: 0x00 -> 0xA5. DATA reads 0 through edge 7 and 0xA5 from edge 8.
    iDIn = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_reg($sformatf("lat_e%0d", k), A_DATA, (k < 8) ? 32'h0 : 32'hA5);
    end
    check_reg("lat_status", A_STATUS, 32'h0);
    iDIn = 8'h00;
    repeat (10) tick();
    check_reg("lat_back0", A_DATA, 32'h0);

    // Rising edge on bit 0: STATUS sets at edge 8, oIRQ at edge 9, then W1C
    bus_write(A_RISE, 32'h1);
    iDIn = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 7) check_reg("rise_st_e7", A_STATUS, 32'h0);
      if (k == 8) begin
        check_reg("rise_st_e8", A_STATUS, 32'h1);
        check("rise_irq_e8", {31'b0, oIRQ}, 32'h0);
      end
      if (k == 9) check("rise_irq_e9", {31'b0, oIRQ}, 32'h1);
    end
    bus_write(A_STATUS, 32'h1);
    check_reg("w1c_status", A_STATUS, 32'h0);
    check("w1c_irq_same", {31'b0, oIRQ}, 32'h1);
    tick();
    check("w1c_irq_next", {31'b0, oIRQ}, 32'h0);

    // A fall with FALL_EN=0 sets nothing.
    bus_write(A_RISE, 32'h0);
    iDIn = 8'h00;
    repeat (10) tick();
    check_reg("nofall_status", A_STATUS, 32'h0);

    // A 4-cycle pulse is filtered out. A 5-cycle pulse gets through and produces both edges.
    bus_write(A_RISE, 32'hFF);
    bus_write(A_FALL, 32'hFF);
    iDIn = 8'h08;
    repeat (4) tick();
    iDIn = 8'h00;
    repeat (12) tick();
    check_reg("p4_data", A_DATA, 32'h0);
    check_reg("p4_status", A_STATUS, 32'h0);
    check("p4_irq", {31'b0, oIRQ}, 32'h0);
    iDIn = 8'h08;
    repeat (5) tick();
    iDIn = 8'h00;
    repeat (12) tick();
    check_reg("p5_status", A_STATUS, 32'h08);
    check_reg("p5_data", A_DATA, 32'h0);
    check("p5_irq", {31'b0, oIRQ}, 32'h1);
    bus_write(A_STATUS, 32'hFF);
    tick();
    check("p5_irq_clr", {31'b0, oIRQ}, 32'h0);
    bus_write(A_RISE, 32'h0);
    bus_write(A_FALL, 32'h0);

    // Set wins over clear: a fall on bit 7 and a W1C of bit 7 on the same edge
    iDIn = 8'h80;
    repeat (10) tick();
    check_reg("sw_pre_data", A_DATA, 32'h80);
    bus_write(A_FALL, 32'h80);
    iDIn = 8'h00;
    repeat (7) tick();
    check_reg("sw_st_e7", A_STATUS, 32'h0);
    bus_write(A_STATUS, 32'h80);
    check_reg("sw_st_e8", A_STATUS, 32'h80);
    check_reg("sw_data_e8", A_DATA, 32'h0);
    // Clearing the enable must not clear STATUS.
    bus_write(A_FALL, 32'h0);
    check_reg("sw_keep", A_STATUS, 32'h80);
    bus_write(A_STATUS, 32'h80);
    check_reg("sw_clr", A_STATUS, 32'h0);

    // Register width, ignored writes, read gating, oACK
    bus_write(A_RISE, 32'hFFFF_FFFF);
    check_reg("rise_width", A_RISE, 32'hFF);
    bus_write(A_FALL, 32'h1234_565A);
    check_reg("fall_width", A_FALL, 32'h5A);
    bus_write(A_DATA, 32'hFFFF_FFFF);
    check_reg("data_ro", A_DATA, 32'h0);
    bus.iADR = A_RISE;
    bus.iWE  = 1'b0;
    bus.iSTB = 1'b1;
    #1;
    check("ack_rd", {31'b0, bus.oACK}, 32'h1);
    bus.iWE = 1'b1;
    #1;
    check("odat_we", bus.oDAT, 32'h0);
    check("ack_we", {31'b0, bus.oACK}, 32'h1);
    bus.iSTB = 1'b0;
    bus.iWE  = 1'b0;
    #1;
    check("odat_nostb", bus.oDAT, 32'h0);
    check("ack_nostb", {31'b0, bus.oACK}, 32'h0);
    bus_write(A_RISE, 32'h0);
    bus_write(A_FALL, 32'h0);

    // Reset mid-debounce and mid-transfer with STATUS=0x0F
    bus_write(A_RISE, 32'h0F);
    iDIn = 8'h0F;
    repeat (10) tick();
    check_reg("pre_rst_status", A_STATUS, 32'h0F);
    check("pre_rst_irq", {31'b0, oIRQ}, 32'h1);
    iDIn = 8'hF0;
    n = $urandom_range(4, 7);
    repeat (n) tick();
    bus.iADR = A_FALL;
    bus.iDAT = 32'hFF;
    bus.iWE  = 1'b1;
    bus.iSTB = 1'b1;
    #2;
    iRST = 1'b1;
    #1;
    bus.iSTB = 1'b0;
    bus.iWE  = 1'b0;
    check_reg("rst_mid_data", A_DATA, 32'h0);
    check_reg("rst_mid_rise", A_RISE, 32'h0);
    check_reg("rst_mid_fall", A_FALL, 32'h0);
    check_reg("rst_mid_status", A_STATUS, 32'h0);
    check("rst_mid_irq", {31'b0, oIRQ}, 32'h0);
    tick();
    iRST = 1'b0;
    // The input is already high at release. RISE_EN is written on edge 1,
    // before stable rises on edge 8.
    bus_write(A_RISE, 32'hF0);
    check_reg("post_rst_data_e1", A_DATA, 32'h0);
    repeat (9) tick();
    check_reg("post_rst_data", A_DATA, 32'hF0);
    check_reg("post_rst_status", A_STATUS, 32'hF0);
    check("post_rst_irq", {31'b0, oIRQ}, 32'h1);

    // Final report
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
